// File: rtl/count_bounce_monitor_pkg.sv
// Shared definitions for the mod-25 bounce counter and its receive-side monitor.
package count_bounce_monitor_pkg;

    localparam logic [2:0] MON_IDLE  = 3'd0;
    localparam logic [2:0] MON_LOAD  = 3'd1;
    localparam logic [2:0] MON_UP    = 3'd2;
    localparam logic [2:0] MON_DOWN  = 3'd3;
    localparam logic [2:0] MON_FAULT = 3'd4;

    // Rails shared with the counter control unit.
    localparam int DEF_TOP = 25;
    localparam int DEF_BOT = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = MON_IDLE,
        ST_LOAD  = MON_LOAD,
        ST_UP    = MON_UP,
        ST_DOWN  = MON_DOWN,
        ST_FAULT = MON_FAULT
    } mon_state_e;

endpackage

// File: rtl/count_bounce_monitor_if.sv
// Count bus between the bounce counter (master) and its monitor (slave).
interface count_bounce_monitor_if #(
    parameter int WIDTH = 5
) ();
    logic [WIDTH-1:0] count;
    logic             count_valid;

    modport master (output count, output count_valid);
    modport slave  (input  count, input  count_valid);
endinterface

// File: rtl/count_bounce_monitor_step_checker.sv
// Combinational step classifier: decides whether count is a legal successor of prev in a phase.
module count_bounce_monitor_step_checker
    import count_bounce_monitor_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int TOP   = DEF_TOP,
    parameter int BOT   = DEF_BOT
) (
    input  logic [WIDTH-1:0] prev,
    input  logic [WIDTH-1:0] count,
    input  mon_state_e       phase,
    output logic             is_inc,
    output logic             is_dec,
    output logic             at_top,
    output logic             at_bot,
    output logic             legal
);
    localparam logic [WIDTH:0] TOP_X = (WIDTH+1)'(TOP);
    localparam logic [WIDTH:0] BOT_X = (WIDTH+1)'(BOT);
    localparam logic [WIDTH:0] ONE_X = (WIDTH+1)'(1);

    // One guard bit keeps prev-1 at 0 from aliasing with a count of all-ones.
    logic [WIDTH:0] prev_x;
    logic [WIDTH:0] count_x;

    assign prev_x  = {1'b0, prev};
    assign count_x = {1'b0, count};

    assign is_inc = (count_x == prev_x + ONE_X);
    assign is_dec = (count_x == prev_x - ONE_X);
    assign at_top = (prev_x == TOP_X);
    assign at_bot = (prev_x == BOT_X);

    always_comb begin
        legal = 1'b0;
        case (phase)
            ST_LOAD: legal = (is_inc && !at_top) || (is_dec && !at_bot);
            ST_UP:   legal = at_top ? (count_x == TOP_X - ONE_X) : is_inc;
            ST_DOWN: legal = at_bot ? (count_x == BOT_X + ONE_X) : is_dec;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/count_bounce_monitor.sv
// Reconstructs the bounce counter's phase from its count bus, counts rail reversals
// and latches the first illegal sample.
module count_bounce_monitor
    import count_bounce_monitor_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int TOP   = DEF_TOP,
    parameter int BOT   = DEF_BOT,
    parameter int REV_W = 8
) (
    input  logic                     clock,
    input  logic                     restart_n,
    count_bounce_monitor_if.slave    bus,
    output logic                     dir_up,
    output logic [2:0]               phase,
    output logic                     rev_pulse,
    output logic [REV_W-1:0]         rev_count,
    output logic                     step_err,
    output logic [WIDTH-1:0]         err_value
);
    localparam logic [WIDTH:0] TOP_X = (WIDTH+1)'(TOP);

    mon_state_e       state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             rev_pulse_q, rev_pulse_d;
    logic [REV_W-1:0] rev_count_q, rev_count_d;
    logic             step_err_q, step_err_d;
    logic [WIDTH-1:0] err_value_q, err_value_d;

    logic is_inc, is_dec, at_top, at_bot, legal;
    logic reversal;

    count_bounce_monitor_step_checker #(
        .WIDTH (WIDTH),
        .TOP   (TOP),
        .BOT   (BOT)
    ) u_step_checker (
        .prev   (prev_q),
        .count  (bus.count),
        .phase  (state_q),
        .is_inc (is_inc),
        .is_dec (is_dec),
        .at_top (at_top),
        .at_bot (at_bot),
        .legal  (legal)
    );

    assign reversal = legal && (((state_q == ST_UP) && at_top) ||
                                ((state_q == ST_DOWN) && at_bot));

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        rev_pulse_d = 1'b0;
        rev_count_d = rev_count_q;
        step_err_d  = step_err_q;
        err_value_d = err_value_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.count_valid) begin
                    if ({1'b0, bus.count} > TOP_X) begin
                        state_d     = ST_FAULT;
                        step_err_d  = 1'b1;
                        err_value_d = bus.count;
                    end else begin
                        state_d = ST_LOAD;
                        prev_d  = bus.count;
                    end
                end
            end
            ST_LOAD, ST_UP, ST_DOWN: begin
                if (!bus.count_valid) begin
                    state_d = ST_IDLE;
                end else if (!legal) begin
                    state_d     = ST_FAULT;
                    step_err_d  = 1'b1;
                    err_value_d = bus.count;
                end else begin
                    prev_d = bus.count;
                    if (is_inc)
                        state_d = ST_UP;
                    else if (is_dec)
                        state_d = ST_DOWN;
                    if (reversal) begin
                        rev_pulse_d = 1'b1;
                        if (rev_count_q != '1)
                            rev_count_d = rev_count_q + REV_W'(1);
                    end
                end
            end
            // FAULT is absorbing; only restart_n leaves it.
            default: state_d = ST_FAULT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!restart_n) begin
            state_q     <= ST_IDLE;
            prev_q      <= '0;
            rev_pulse_q <= 1'b0;
            rev_count_q <= '0;
            step_err_q  <= 1'b0;
            err_value_q <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            rev_pulse_q <= rev_pulse_d;
            rev_count_q <= rev_count_d;
            step_err_q  <= step_err_d;
            err_value_q <= err_value_d;
        end
    end

    assign dir_up    = (state_q == ST_UP);
    assign phase     = state_q;
    assign rev_pulse = rev_pulse_q;
    assign rev_count = rev_count_q;
    assign step_err  = step_err_q;
    assign err_value = err_value_q;

endmodule

// File: tb/tb_count_bounce_monitor.sv
// Directed and randomized bench for count_bounce_monitor against an integer reference model.
module tb_count_bounce_monitor;

    localparam int TOP  = 25;
    localparam int BOT  = 0;
    localparam int RMAX = 255;
    // Phase encoding as published for the monitor's phase output.
    localparam int P_IDLE = 0, P_LOAD = 1, P_UP = 2, P_DOWN = 3, P_FAULT = 4;

    logic       clock = 1'b0;
    logic       restart_n = 1'b0;
    logic       dir_up, rev_pulse, step_err;
    logic [2:0] phase;
    logic [7:0] rev_count;
    logic [4:0] err_value;

    count_bounce_monitor_if #(.WIDTH(5)) bus ();

    count_bounce_monitor #(
        .WIDTH (5),
        .TOP   (TOP),
        .BOT   (BOT),
        .REV_W (8)
    ) dut (
        .clock     (clock),
        .restart_n (restart_n),
        .bus       (bus),
        .dir_up    (dir_up),
        .phase     (phase),
        .rev_pulse (rev_pulse),
        .rev_count (rev_count),
        .step_err  (step_err),
        .err_value (err_value)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state, plain integers.
    int m_ph = P_IDLE, m_prev = 0, m_rev = 0, m_pulse = 0, m_err = 0, m_errv = 0;

    // Bounce generator state.
    int pos = 0, dir = 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_fault(input int c);
        m_ph   = P_FAULT;
        m_err  = 1;
        m_errv = c;
    endtask

    task automatic model_step(input bit rst_n, input bit v, input int c);
        bit up_ok, dn_ok, rev;
        m_pulse = 0;
        if (!rst_n) begin
            m_ph = P_IDLE; m_prev = 0; m_rev = 0; m_err = 0; m_errv = 0;
        end else if (m_ph == P_FAULT) begin
            m_ph = P_FAULT;
        end else if (m_ph == P_IDLE) begin
            if (v) begin
                if (c > TOP) model_fault(c);
                else begin m_ph = P_LOAD; m_prev = c; end
            end
        end else if (!v) begin
            m_ph = P_IDLE;
        end else begin
            rev   = (m_ph == P_UP && m_prev == TOP && c == TOP - 1) ||
                    (m_ph == P_DOWN && m_prev == BOT && c == BOT + 1);
            up_ok = (m_ph == P_LOAD || m_ph == P_UP) && m_prev < TOP && c == m_prev + 1;
            dn_ok = (m_ph == P_LOAD || m_ph == P_DOWN) && m_prev > BOT && c == m_prev - 1;
            if (rev) begin
                m_ph    = (m_ph == P_UP) ? P_DOWN : P_UP;
                m_pulse = 1;
                if (m_rev < RMAX) m_rev++;
                m_prev  = c;
            end else if (up_ok) begin
                m_ph = P_UP; m_prev = c;
            end else if (dn_ok) begin
                m_ph = P_DOWN; m_prev = c;
            end else begin
                model_fault(c);
            end
        end
    endtask

    task automatic step(input bit rst_n, input bit v, input int c);
        restart_n       = rst_n;
        bus.count_valid = v;
        bus.count       = 5'(c);
        @(posedge clock);
        model_step(rst_n, v, c);
        #1;
        chk("phase", int'(phase), m_ph);
        chk("dir_up", int'(dir_up), (m_ph == P_UP) ? 1 : 0);
        chk("rev_pulse", int'(rev_pulse), m_pulse);
        chk("rev_count", int'(rev_count), m_rev);
        chk("step_err", int'(step_err), m_err);
        chk("err_value", int'(err_value), m_errv);
    endtask

    task automatic bounce_next();
        pos = pos + dir;
        if (pos > TOP) begin dir = -1; pos = TOP - 1; end
        if (pos < BOT) begin dir = 1;  pos = BOT + 1; end
    endtask

    initial begin
        bus.count_valid = 1'b0;
        bus.count       = '0;

        // Reset state, with count_valid high to show reset dominates.
        step(0, 1, 7);
        chk("reset_phase", int'(phase), P_IDLE);
        chk("reset_revcnt", int'(rev_count), 0);

        // 1: load 15, up to 25, down to 0, up to 1.
        step(1, 1, 15);
        chk("s1_load", int'(phase), P_LOAD);
        for (int v = 16; v <= 25; v++) step(1, 1, v);
        for (int v = 24; v >= 0; v--) begin
            step(1, 1, v);
            if (v == 24) chk("s1_pulse24", int'(rev_pulse), 1);
        end
        step(1, 1, 1);
        chk("s1_pulse1", int'(rev_pulse), 1);
        chk("s1_revcnt", int'(rev_count), 2);
        chk("s1_err", int'(step_err), 0);

        // 2: load 10, down to 0, then 1, 2.
        step(0, 0, 0);
        step(1, 1, 10);
        for (int v = 9; v >= 0; v--) step(1, 1, v);
        chk("s2_down", int'(phase), P_DOWN);
        step(1, 1, 1);
        chk("s2_dir", int'(dir_up), 1);
        step(1, 1, 2);
        chk("s2_revcnt", int'(rev_count), 1);

        // 3: overshoot past the top rail.
        step(0, 0, 0);
        step(1, 1, 25);
        step(1, 1, 26);
        chk("s3_phase", int'(phase), P_FAULT);
        chk("s3_err", int'(step_err), 1);
        chk("s3_errv", int'(err_value), 26);
        step(1, 1, 3);
        step(1, 1, 7);
        chk("s3_errv_hold", int'(err_value), 26);

        // 4: skipped value, then 0 -> 31 wrap.
        step(0, 0, 0);
        step(1, 1, 3); step(1, 1, 4); step(1, 1, 6);
        chk("s4_skip_errv", int'(err_value), 6);
        step(0, 0, 0);
        step(1, 1, 0); step(1, 1, 31);
        chk("s4_wrap_phase", int'(phase), P_FAULT);
        chk("s4_wrap_errv", int'(err_value), 31);

        // 5: drop count_valid mid-UP, resume elsewhere as a fresh load.
        step(0, 0, 0);
        step(1, 1, 1); step(1, 1, 0);
        for (int v = 1; v <= 12; v++) step(1, 1, v);
        step(1, 0, 12);
        chk("s5_idle", int'(phase), P_IDLE);
        step(1, 1, 20);
        chk("s5_load", int'(phase), P_LOAD);
        step(1, 1, 21);
        chk("s5_up", int'(phase), P_UP);
        chk("s5_revcnt", int'(rev_count), 1);

        // 6: reset out of FAULT with count_valid still high.
        step(1, 1, 21);
        chk("s6_fault", int'(phase), P_FAULT);
        step(0, 1, 22);
        chk("s6_phase", int'(phase), P_IDLE);
        chk("s6_err", int'(step_err), 0);
        chk("s6_errv", int'(err_value), 0);

        // Long bounce run to saturate rev_count.
        step(0, 0, 0);
        pos = 0; dir = 1;
        step(1, 1, pos);
        for (int i = 0; i < 6600; i++) begin
            bounce_next();
            step(1, 1, pos);
        end
        chk("sat_revcnt", int'(rev_count), RMAX);

        // Randomized mix of bounces, drops, stray values and resets.
        step(0, 0, 0);
        pos = $urandom_range(BOT, TOP);
        dir = ($urandom_range(0, 1) == 1) ? 1 : -1;
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (m_ph == P_FAULT && r < 15) begin
                step(0, $urandom_range(0, 1), $urandom_range(0, 31));
                pos = $urandom_range(BOT, TOP);
            end else if (r < 4) begin
                step(1, 0, $urandom_range(0, 31));
                pos = $urandom_range(BOT, TOP);
            end else if (r < 6) begin
                step(1, 1, $urandom_range(0, 31));
            end else begin
                bounce_next();
                step(1, 1, pos);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
